commit_arbiter: RTL and testbench

//  Parametrised writeback/commit arbiter between execute-stage functional units and the commit stage.

---
 rtl/commit_arbiter.sv | 141 ++++++++++++++
 tb/tb_commit_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_arbiter.sv
// Writeback/commit arbiter: one result FIFO per functional unit, up to N_PORT
// queue heads granted per cycle onto commit buses that also drive busy-table wakeup.
module commit_arbiter #(
    parameter int N_FU    = 6,
    parameter int N_PORT  = 2,
    parameter int DEPTH   = 2,
    parameter int DATA_W  = 128,
    parameter int DEST_W  = 6,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N_FU-1:0]          fu_valid,
    output logic [N_FU-1:0]          fu_ready,
    input  logic [N_FU*DATA_W-1:0]   fu_data,
    input  logic [N_FU*DEST_W-1:0]   fu_dest,
    output logic [N_PORT-1:0]        cm_valid,
    input  logic                     cm_ready,
    output logic [N_PORT*DATA_W-1:0] cm_data,
    output logic [N_PORT-1:0]        wake_valid,
    output logic [N_PORT*DEST_W-1:0] wake_dest
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(N_FU);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
    localparam logic [FW-1:0] LAST_FU   = FW'(N_FU - 1);

    logic [DATA_W-1:0] r_data [N_FU][DEPTH];
    logic [DEST_W-1:0] r_dest [N_FU][DEPTH];
    logic [PW-1:0]     r_head [N_FU];
    logic [PW-1:0]     r_tail [N_FU];
    logic [CW-1:0]     r_cnt  [N_FU];
    logic [FW-1:0]     r_ptr;

    logic [N_FU-1:0]   w_push;
    logic [N_FU-1:0]   w_pop;
    logic [N_FU-1:0]   w_grant;
    logic [N_PORT-1:0] w_port_vld;
    logic [FW-1:0]     w_port_fu [N_PORT];
    logic [FW-1:0]     w_last;
    logic [FW-1:0]     w_start;

    // Ready looks only at registered occupancy, so a full queue never accepts
    // even when its head is leaving this cycle.
    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < N_FU; i++) begin
            fu_ready[i] = (r_cnt[i] != FULL_CNT) && !flush && !reset;
        end
    end

    assign w_push  = fu_valid & fu_ready;
    assign w_pop   = w_grant & {N_FU{cm_ready && !flush && !reset}};
    assign w_start = (RR_MODE != 0) ? r_ptr : '0;

    // Scan from the start index with wrap; the n-th non-empty queue lands on port n.
    always_comb begin
        int n;
        int s;
        logic [FW-1:0] idx;
        n          = 0;
        s          = 0;
        idx        = '0;
        w_grant    = '0;
        w_port_vld = '0;
        w_last     = '0;
        for (int k = 0; k < N_PORT; k++) begin
            w_port_fu[k] = '0;
        end
        for (int off = 0; off < N_FU; off++) begin
            s = int'(w_start) + off;
            if (s >= N_FU) begin
                s = s - N_FU;
            end
            idx = FW'(s);
            if ((r_cnt[idx] != '0) && (n < N_PORT)) begin
                w_grant[idx] = 1'b1;
                for (int k = 0; k < N_PORT; k++) begin
                    if (k == n) begin
                        w_port_vld[k] = 1'b1;
                        w_port_fu[k]  = idx;
                    end
                end
                w_last = idx;
                n      = n + 1;
            end
        end
    end

    // Heads stay visible during a flush cycle, but nothing may wake then.
    always_comb begin
        cm_valid   = w_port_vld & {N_PORT{!reset}};
        wake_valid = cm_valid & {N_PORT{cm_ready && !flush}};
        cm_data    = '0;
        wake_dest  = '0;
        for (int k = 0; k < N_PORT; k++) begin
            if (cm_valid[k]) begin
                cm_data[k*DATA_W +: DATA_W]   = r_data[w_port_fu[k]][r_head[w_port_fu[k]]];
                wake_dest[k*DEST_W +: DEST_W] = r_dest[w_port_fu[k]][r_head[w_port_fu[k]]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < N_FU; i++) begin
                r_head[i] <= '0;
                r_tail[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (w_push[i]) begin
                    r_tail[i] <= (r_tail[i] == LAST_SLOT) ? '0 : r_tail[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_head[i] <= (r_head[i] == LAST_SLOT) ? '0 : r_head[i] + 1'b1;
                end
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
            if (cm_ready && (|w_grant)) begin
                r_ptr <= (w_last == LAST_FU) ? '0 : w_last + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (w_push[i]) begin
                r_data[i][r_tail[i]] <= fu_data[i*DATA_W +: DATA_W];
                r_dest[i][r_tail[i]] <= fu_dest[i*DEST_W +: DEST_W];
            end
        end
    end

endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: queue-based reference model feeding a scoreboard,
// plus two narrow instances exercising fixed versus round-robin starvation.
module tb_commit_arbiter;
    localparam int N_FU    = 6;
    localparam int N_PORT  = 2;
    localparam int DEPTH   = 2;
    localparam int DATA_W  = 128;
    localparam int DEST_W  = 6;
    localparam int RR_MODE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset, flush, cm_ready;
    logic [N_FU-1:0]          fu_valid, fu_ready;
    logic [N_FU*DATA_W-1:0]   fu_data;
    logic [N_FU*DEST_W-1:0]   fu_dest;
    logic [N_PORT-1:0]        cm_valid, wake_valid;
    logic [N_PORT*DATA_W-1:0] cm_data;
    logic [N_PORT*DEST_W-1:0] wake_dest;

    commit_arbiter #(.N_FU(N_FU), .N_PORT(N_PORT), .DEPTH(DEPTH), .DATA_W(DATA_W),
                     .DEST_W(DEST_W), .RR_MODE(RR_MODE)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_data(fu_data), .fu_dest(fu_dest), .cm_valid(cm_valid), .cm_ready(cm_ready),
        .cm_data(cm_data), .wake_valid(wake_valid), .wake_dest(wake_dest));

    // Narrow single-port instances: fixed priority and round-robin.
    logic [N_FU-1:0]   s_valid;
    logic [N_FU*8-1:0] s_data;
    logic [N_FU*6-1:0] s_dest;
    logic [N_FU-1:0]   f_ready, a_ready;
    logic [0:0]        f_cm_valid, f_wake_valid, a_cm_valid, a_wake_valid;
    logic [7:0]        f_cm_data, a_cm_data;
    logic [5:0]        f_wake_dest, a_wake_dest;

    commit_arbiter #(.N_FU(6), .N_PORT(1), .DEPTH(2), .DATA_W(8), .DEST_W(6), .RR_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .flush(1'b0), .fu_valid(s_valid), .fu_ready(f_ready),
        .fu_data(s_data), .fu_dest(s_dest), .cm_valid(f_cm_valid), .cm_ready(1'b1),
        .cm_data(f_cm_data), .wake_valid(f_wake_valid), .wake_dest(f_wake_dest));

    commit_arbiter #(.N_FU(6), .N_PORT(1), .DEPTH(2), .DATA_W(8), .DEST_W(6), .RR_MODE(1)) u_alt (
        .clk(clk), .reset(reset), .flush(1'b0), .fu_valid(s_valid), .fu_ready(a_ready),
        .fu_data(s_data), .fu_dest(s_dest), .cm_valid(a_cm_valid), .cm_ready(1'b1),
        .cm_data(a_cm_data), .wake_valid(a_wake_valid), .wake_dest(a_wake_dest));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-FU queues, commit expectations and per-cycle masks.
    typedef struct { logic [DATA_W-1:0] d; logic [DEST_W-1:0] t; } ent_t;
    typedef struct { int port; logic [DATA_W-1:0] d; logic [DEST_W-1:0] t; } cm_t;
    typedef struct { logic [N_PORT-1:0] v; logic [N_PORT-1:0] w; logic [N_FU-1:0] r; } cyc_t;

    ent_t mq[N_FU][$];
    cm_t  eq[$];
    cyc_t cq[$];
    int   m_ptr = 0;

    always @(negedge clk) begin
        cyc_t c;
        ent_t e;
        int   g[$];
        int   st;
        g.delete();
        c.v = '0; c.w = '0; c.r = '0;
        if (reset) begin
            for (int i = 0; i < N_FU; i++) mq[i].delete();
            m_ptr = 0;
        end else begin
            st = (RR_MODE != 0) ? m_ptr : 0;
            for (int o = 0; o < N_FU; o++) begin
                if (mq[(st + o) % N_FU].size() > 0 && g.size() < N_PORT) g.push_back((st + o) % N_FU);
            end
            for (int k = 0; k < g.size(); k++) c.v[k] = 1'b1;
            for (int i = 0; i < N_FU; i++) c.r[i] = !flush && (mq[i].size() < DEPTH);
            if (flush) begin
                for (int i = 0; i < N_FU; i++) mq[i].delete();
                m_ptr = 0;
            end else begin
                if (cm_ready) begin
                    for (int k = 0; k < g.size(); k++) begin
                        c.w[k] = 1'b1;
                        e = mq[g[k]].pop_front();
                        eq.push_back('{k, e.d, e.t});
                    end
                    if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % N_FU;
                end
                for (int i = 0; i < N_FU; i++) begin
                    if (fu_valid[i] && c.r[i]) begin
                        e.d = fu_data[i*DATA_W +: DATA_W];
                        e.t = fu_dest[i*DEST_W +: DEST_W];
                        mq[i].push_back(e);
                    end
                end
            end
        end
        cq.push_back(c);
    end

    always @(negedge clk) begin
        cyc_t c;
        cm_t  e;
        #1;
        if (cq.size() == 0) begin
            chk("cycle_expectation_present", 0, 1);
        end else begin
            c = cq.pop_front();
            chk("cm_valid", cm_valid, c.v);
            chk("wake_valid", wake_valid, c.w);
            chk("fu_ready", fu_ready, c.r);
            for (int k = 0; k < N_PORT; k++) begin
                if (wake_valid[k]) begin
                    if (eq.size() == 0) begin
                        chk("unexpected_commit", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("commit_port", k, e.port);
                        chk("commit_data", cm_data[k*DATA_W +: DATA_W], e.d);
                        chk("commit_dest", wake_dest[k*DEST_W +: DEST_W], e.t);
                    end
                end else if (!cm_valid[k]) begin
                    chk("idle_data_zero", cm_data[k*DATA_W +: DATA_W], 0);
                    chk("idle_dest_zero", wake_dest[k*DEST_W +: DEST_W], 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic drive_fu(input int i, input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] t);
        fu_valid[i] = 1'b1;
        fu_data[i*DATA_W +: DATA_W] = d;
        fu_dest[i*DEST_W +: DEST_W] = t;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic          acc;
        int            idx;
        int            w;
        logic [DATA_W-1:0] items [3];
        reset = 1'b1; flush = 1'b0; cm_ready = 1'b1;
        fu_valid = '0; fu_data = '0; fu_dest = '0;
        s_valid = '0; s_data = '0; s_dest = '0;
        for (int i = 0; i < N_FU; i++) begin
            s_data[i*8 +: 8] = 8'(i);
            s_dest[i*6 +: 6] = 6'(i + 1);
        end

        // Reset held for two cycles, then released.
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single result from FU2.
        drive_fu(2, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 6'd5);
        tick();
        idle_inputs();
        tick(); tick(); tick();

        // All six FUs push once after a fresh reset.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N_FU; i++) drive_fu(i, DATA_W'(128'h1000 + i), DEST_W'(10 + i));
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();

        // Back-pressure on FU0 with three items into a depth-2 queue.
        items[0] = 128'hA; items[1] = 128'hB; items[2] = 128'hC;
        cm_ready = 1'b0;
        idx = 0; w = 0;
        drive_fu(0, items[0], 6'd20);
        while (idx < 3 && w < 40) begin
            @(negedge clk);
            acc = fu_ready[0];
            tick();
            w++;
            if (w == 5) cm_ready = 1'b1;
            if (acc) begin
                idx++;
                if (idx < 3) drive_fu(0, items[idx], DEST_W'(20 + idx));
                else fu_valid[0] = 1'b0;
            end
        end
        chk("backpressure_items_accepted", idx, 3);
        for (int i = 0; i < 4; i++) tick();

        // Two queued entries then a flush while FU1 is presenting.
        cm_ready = 1'b0;
        drive_fu(3, 128'h33, 6'd33);
        drive_fu(4, 128'h44, 6'd44);
        tick();
        idle_inputs();
        drive_fu(1, 128'h11, 6'd11);
        flush = 1'b1;
        tick();
        idle_inputs();
        cm_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Randomised traffic with occasional flush and reset.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N_FU; i++) begin
                fu_valid[i] = ($urandom_range(0, 99) < 60);
                fu_data[i*DATA_W +: DATA_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
                fu_dest[i*DEST_W +: DEST_W] = DEST_W'($urandom_range(0, 63));
            end
            cm_ready = ($urandom_range(0, 99) < 70);
            flush    = ($urandom_range(0, 99) < 3);
            reset    = ($urandom_range(0, 199) < 1);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        cm_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        #2;
        chk("all_expected_commits_seen", eq.size(), 0);

        // FU0 and FU5 always valid on the single-port instances.
        s_valid = 6'b100001;
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("fixed_valid", {f_cm_valid, f_wake_valid}, 2'b11);
            chk("fixed_grants_fu0", f_wake_dest, 6'd1);
            chk("rr_valid", {a_cm_valid, a_wake_valid}, 2'b11);
            chk("rr_alternates", a_wake_dest, (i % 2 == 0) ? 6'd1 : 6'd6);
            tick();
        end
        s_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
